// File: rtl/siso_shift_ctrl.sv
// siso_shift_ctrl: sequencing controller for an external DEPTH-stage SISO
// shift register. Accepts a parallel word (valid/ready), drives it MSB-first
// onto si, flushes the register with FILL, captures the bits emerging on so
// and presents the recovered word (valid/ready).
//
// Optional feature macro: LOOPBACK_CHECK_EN (adds chk_err, set on DONE entry
// when the recovered word differs from the word sent).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   producer has a word on in_data
//   in_data    parallel word to serialise
//   in_ready   controller can accept a word (IDLE only)
//   si         serial bit to the SISO register input
//   shift_en   SISO register shift enable
//   so         serial output of the SISO register
//   out_valid  recovered word available
//   out_data   recovered word, MSB first-received
//   out_ready  consumer accepts out_data
//   busy       high in SHIFT or DONE
//   chk_err    (LOOPBACK_CHECK_EN only) loopback compare error
module siso_shift_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter logic        FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             si,
  output logic             shift_en,
  input  logic             so,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
`ifdef LOOPBACK_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int unsigned TOTAL = WIDTH + DEPTH;
  localparam int unsigned CW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] cap_next;
`ifdef LOOPBACK_CHECK_EN
  logic [WIDTH-1:0] tx;
`endif

  // Capture register with so appended at the LSB (top bit drops off).
  assign cap_next = WIDTH'({cap, so});

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_sh     <= '0;
      cap       <= '0;
      in_ready  <= 1'b1;
      si        <= 1'b0;
      shift_en  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
`ifdef LOOPBACK_CHECK_EN
      tx        <= '0;
      chk_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // MSB goes out immediately; tx_sh holds the remaining bits.
            state    <= SHIFT;
            cnt      <= '0;
            si       <= in_data[WIDTH-1];
            tx_sh    <= in_data << 1;
            shift_en <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef LOOPBACK_CHECK_EN
            tx       <= in_data;
`endif
          end
        end

        SHIFT: begin
          cnt <= cnt + CW'(1);
          // Bits sent at cnt=k reach so during cnt=k+DEPTH.
          if (cnt >= CW'(DEPTH)) begin
            cap <= cap_next;
          end
          if (cnt == CW'(TOTAL - 1)) begin
            state     <= DONE;
            shift_en  <= 1'b0;
            si        <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= cap_next;
`ifdef LOOPBACK_CHECK_EN
            chk_err   <= (cap_next != tx);
`endif
          end else begin
            // Value for the next cycle: data bits while any remain, then FILL.
            si    <= (cnt < CW'(WIDTH - 1)) ? tx_sh[WIDTH-1] : FILL;
            tx_sh <= tx_sh << 1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          si        <= 1'b0;
          shift_en  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// tb_siso_shift_ctrl: directed + randomized bench for siso_shift_ctrl with an
// ideal DEPTH-stage SISO register model and a word-level reference model.
module tb_siso_shift_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic        FILL  = 1'b0;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             si;
  logic             shift_en;
  logic             so;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;
`ifdef LOOPBACK_CHECK_EN
  logic             chk_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // External SISO register model; flip corrupts one sampled so bit.
  logic [DEPTH-1:0] siso = '0;
  logic             flip = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (shift_en) siso <= {siso[DEPTH-2:0], si};
  end

  assign so = siso[DEPTH-1] ^ flip;

  siso_shift_ctrl #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .FILL (FILL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .si       (si),
    .shift_en (shift_en),
    .so       (so),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy)
`ifdef LOOPBACK_CHECK_EN
    ,
    .chk_err  (chk_err)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction from IDLE. hold: cycles out_ready stays low in DONE;
  // hold_valid: drive in_valid during the hold and on the release cycle;
  // flip_j: index (first received = 0) of the captured bit to corrupt, -1 none.
  task automatic send(input logic [WIDTH-1:0] w, input int hold, input bit hold_valid,
                      input int flip_j);
    logic [WIDTH-1:0] exp_out;
    logic             exp_si;
    exp_out = w;
    if (flip_j >= 0) exp_out[WIDTH-1-flip_j] = ~exp_out[WIDTH-1-flip_j];
    chk1("pre_in_ready", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_data   = w;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    for (int k = 0; k < int'(WIDTH + DEPTH); k++) begin
      exp_si = (k < int'(WIDTH)) ? w[WIDTH-1-k] : FILL;
      chk1("shift_en", shift_en, 1'b1);
      chk1("si", si, exp_si);
      chk1("shift_out_valid", out_valid, 1'b0);
      chk1("shift_in_ready", in_ready, 1'b0);
      chk1("shift_busy", busy, 1'b1);
      flip = (flip_j >= 0) && (k == int'(DEPTH) + flip_j);
      @(negedge clk);
    end
    flip = 1'b0;
    chk1("done_out_valid", out_valid, 1'b1);
    chkw("done_out_data", out_data, exp_out);
    chk1("done_shift_en", shift_en, 1'b0);
    chk1("done_si", si, 1'b0);
    chk1("done_busy", busy, 1'b1);
    chk1("done_in_ready", in_ready, 1'b0);
`ifdef LOOPBACK_CHECK_EN
    chk1("chk_err", chk_err, flip_j >= 0);
`endif
    for (int h = 0; h < hold; h++) begin
      if (hold_valid) begin
        in_valid = 1'b1;
        in_data  = WIDTH'($urandom);
      end
      @(negedge clk);
      chk1("hold_out_valid", out_valid, 1'b1);
      chkw("hold_out_data", out_data, exp_out);
      chk1("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    in_valid  = hold_valid;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk1("post_in_ready", in_ready, 1'b1);
    chk1("post_out_valid", out_valid, 1'b0);
    chk1("post_busy", busy, 1'b0);
    if (hold_valid) begin
      // in_valid seen in DONE must not have been taken as an accept.
      @(negedge clk);
      chk1("no_accept_in_done", in_ready, 1'b1);
      chk1("no_accept_shift_en", shift_en, 1'b0);
    end
  endtask

  initial begin
    int               acc;
    int               nout;
    int               acc_cyc[2];
    int               out_cyc[2];
    logic [WIDTH-1:0] outs[2];
    bit               saw_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset then idle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_si", si, 1'b0);
    chk1("rst_shift_en", shift_en, 1'b0);
    chkw("rst_out_data", out_data, '0);
`ifdef LOOPBACK_CHECK_EN
    chk1("rst_chk_err", chk_err, 1'b0);
`endif
    @(negedge clk);

    // Basic transfer of 0xB2.
    send(8'hB2, 0, 1'b0, -1);

    // Back-to-back 0xFF then 0x01 with in_valid held high.
    acc  = 0;
    nout = 0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (in_ready && in_valid && acc < 2) begin
        acc_cyc[acc] = c;
        acc++;
      end
      if (out_valid && nout < 2) begin
        outs[nout]    = out_data;
        out_cyc[nout] = c;
        nout++;
      end
      @(negedge clk);
      if (acc == 1) in_data = 8'h01;
      if (acc == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chki("b2b_accepts", acc, 2);
    chki("b2b_outputs", nout, 2);
    if (acc == 2 && nout == 2) begin
      chki("b2b_latency", out_cyc[0] - acc_cyc[0], int'(WIDTH + DEPTH + 1));
      chki("b2b_period", acc_cyc[1] - acc_cyc[0], int'(WIDTH + DEPTH + 2));
      chkw("b2b_word0", outs[0], 8'hFF);
      chkw("b2b_word1", outs[1], 8'h01);
    end
    @(negedge clk);

    // DONE held with out_ready low for 20 cycles while in_valid is offered.
    send(8'hC3, 20, 1'b1, -1);

    // Reset in the middle of SHIFT at cnt=5.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk1("mid_shift_en", shift_en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk1("midrst_shift_en", shift_en, 1'b0);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_si", si, 1'b0);
    saw_valid = 1'b0;
    for (int c = 0; c < int'(WIDTH + DEPTH + 2); c++) begin
      if (out_valid) saw_valid = 1'b1;
      @(negedge clk);
    end
    chk1("midrst_no_out_valid", saw_valid, 1'b0);
    send(8'h3C, 0, 1'b0, -1);

    // Corrupted loopback sample, then a clean resend.
    send(8'h55, 0, 1'b0, 2);
    send(8'h55, 0, 1'b0, -1);

    // Randomized words and consumer stalls.
    for (int i = 0; i < 6; i++) begin
      send(WIDTH'($urandom), int'($urandom_range(0, 3)), 1'(i % 2), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
